// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: turns hazard, taken-branch and SRAM-wait events
// into freeze/bubble/flush strobes, with sticky error flags and saturating statistics.
module pipeline_stall_controller #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 64,
   parameter int HAZ_MAX      = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             clr_stats,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             bubble_id_ex,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             freeze_all,
   output logic             mem_timeout,
   output logic             haz_deadlock,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic [1:0]       state
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] FLUSH    = 2'd1;
   localparam logic [1:0] MEM_WAIT = 2'd2;

   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam int HW = $clog2(HAZ_MAX + 2);
   localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);
   localparam logic [HW-1:0] HMAX = HW'(HAZ_MAX);
   localparam logic [HW-1:0] HSAT = HW'(HAZ_MAX + 1);

   logic [1:0]    state_nxt, ret_state, ret_nxt;
   logic [3:0]    rem_cnt, rem_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;
   logic [HW-1:0] haz_cnt, haz_nxt;
   logic          mstall, fpc, fl, fa, flush_acc;

   assign mstall       = mem_req && !mem_ready;
   assign freeze_pc    = fpc;
   assign freeze_if_id = fpc;
   assign bubble_id_ex = fpc;
   assign flush_if_id  = fl;
   assign flush_id_ex  = fl;
   assign freeze_all   = fa;

   always_comb begin
      fpc       = 1'b0;
      fl        = 1'b0;
      fa        = 1'b0;
      flush_acc = 1'b0;
      state_nxt = state;
      ret_nxt   = ret_state;
      rem_nxt   = rem_cnt;
      wait_nxt  = wait_cnt;
      case (state)
         RUN: begin
            if (mstall) begin
               fa        = 1'b1;
               ret_nxt   = RUN;
               state_nxt = MEM_WAIT;
               wait_nxt  = WW'(1);
            end else if (branch_taken) begin
               fl        = 1'b1;
               flush_acc = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  rem_nxt   = 4'(FLUSH_CYCLES - 1);
                  state_nxt = FLUSH;
               end
            end else if (hazard) begin
               fpc = 1'b1;
            end
         end
         FLUSH: begin
            // a memory stall parks the flush with its remaining count intact
            if (mstall) begin
               fa        = 1'b1;
               ret_nxt   = FLUSH;
               state_nxt = MEM_WAIT;
               wait_nxt  = WW'(1);
            end else begin
               fl      = 1'b1;
               rem_nxt = rem_cnt - 4'd1;
               if (rem_cnt <= 4'd1) state_nxt = RUN;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt = ret_state;
               wait_nxt  = '0;
            end else begin
               fa = 1'b1;
               if (wait_cnt != WMAX) wait_nxt = wait_cnt + WW'(1);
            end
         end
         default: state_nxt = RUN;
      endcase
      haz_nxt = '0;
      if (fpc) haz_nxt = (haz_cnt == HSAT) ? haz_cnt : haz_cnt + HW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         ret_state <= RUN;
         rem_cnt   <= '0;
         wait_cnt  <= '0;
         haz_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_nxt;
         rem_cnt   <= rem_nxt;
         wait_cnt  <= wait_nxt;
         haz_cnt   <= haz_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
         mem_timeout  <= 1'b0;
         haz_deadlock <= 1'b0;
      end else if (clr_stats) begin
         stall_cycles <= '0;
         flush_count  <= '0;
         mem_timeout  <= 1'b0;
         haz_deadlock <= 1'b0;
      end else begin
         if ((fpc || fa) && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_acc && flush_count != '1)    flush_count  <= flush_count + CNT_W'(1);
         if (fa && wait_nxt >= WMAX)            mem_timeout  <= 1'b1;
         if (fpc && haz_nxt > HMAX)             haz_deadlock <= 1'b1;
      end
   end

   a_freeze_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(freeze_all && (flush_if_id || flush_id_ex || bubble_id_ex)));
   a_bubble_eq: assert property (@(posedge clk) disable iff (!rst_n)
      bubble_id_ex == freeze_pc);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized + directed bench for pipeline_stall_controller against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipeline_stall_controller;
   localparam int FC = 2, MT = 64, HM = 8, CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0, rst_n = 1'b0;
   logic hazard = 0, branch_taken = 0, mem_req = 0, mem_ready = 0, clr_stats = 0;
   logic freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze_all;
   logic mem_timeout, haz_deadlock;
   logic [CW-1:0] stall_cycles, flush_count;
   logic [1:0] state;

   pipeline_stall_controller #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .HAZ_MAX(HM), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .hazard(hazard), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .clr_stats(clr_stats),
      .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .bubble_id_ex(bubble_id_ex),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .freeze_all(freeze_all),
      .mem_timeout(mem_timeout), .haz_deadlock(haz_deadlock),
      .stall_cycles(stall_cycles), .flush_count(flush_count), .state(state));

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // model: mode 0=running, 1=flushing, 2=waiting on memory
   int m_mode, m_ret, m_left, m_wait, m_haz, m_stall, m_flush;
   bit m_to, m_dl;
   bit e_hz, e_fl, e_fa, e_acc;

   task automatic m_reset();
      m_mode = 0; m_ret = 0; m_left = 0; m_wait = 0; m_haz = 0;
      m_stall = 0; m_flush = 0; m_to = 0; m_dl = 0;
   endtask

   task automatic m_outputs();
      bit ms;
      ms = mem_req && !mem_ready;
      e_hz = 0; e_fl = 0; e_fa = 0; e_acc = 0;
      if (m_mode == 2)             e_fa = !mem_ready;
      else if (ms)                 e_fa = 1;
      else if (m_mode == 1)        e_fl = 1;
      else if (branch_taken) begin e_fl = 1; e_acc = 1; end
      else if (hazard)             e_hz = 1;
   endtask

   task automatic m_step();
      if (m_mode == 2) begin
         if (mem_ready) begin m_mode = m_ret; m_wait = 0; end
         else m_wait = (m_wait < MT) ? m_wait + 1 : MT;
      end else if (e_fa) begin
         m_ret = m_mode; m_mode = 2; m_wait = 1;
      end else if (m_mode == 1) begin
         m_left--;
         if (m_left <= 0) m_mode = 0;
      end else if (e_acc && FC > 1) begin
         m_mode = 1; m_left = FC - 1;
      end
      m_haz = e_hz ? ((m_haz <= HM) ? m_haz + 1 : HM + 1) : 0;
      if (clr_stats) begin
         m_stall = 0; m_flush = 0; m_to = 0; m_dl = 0;
      end else begin
         if ((e_hz || e_fa) && m_stall < CMAX) m_stall++;
         if (e_acc && m_flush < CMAX) m_flush++;
         if (e_fa && m_wait >= MT) m_to = 1;
         if (e_hz && m_haz > HM) m_dl = 1;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      m_outputs();
      chk("strobes", {26'd0, freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze_all},
          {26'd0, e_hz, e_hz, e_hz, e_fl, e_fl, e_fa});
      chk("state", 32'(state), 32'(m_mode));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      chk("flush_count", 32'(flush_count), 32'(m_flush));
      chk("flags", {30'd0, mem_timeout, haz_deadlock}, {30'd0, m_to, m_dl});
      m_step();
      @(posedge clk); #1;
   endtask

   task automatic drv(input bit h, input bit b, input bit mr, input bit rd, input bit c, input int n);
      hazard = h; branch_taken = b; mem_req = mr; mem_ready = rd; clr_stats = c;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_strobes"}, {26'd0, freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze_all}, 32'd0);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_cnt"}, {16'(stall_cycles), 16'(flush_count)}, 32'd0);
      chk({tag, "_flags"}, {30'd0, mem_timeout, haz_deadlock}, 32'd0);
   endtask

   initial begin
      m_reset();
      #1 chk_reset_state("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // hazard stall 3 cycles
      drv(1, 0, 0, 0, 0, 3);
      drv(0, 0, 0, 0, 0, 1);
      chk("haz3_stall", 32'(stall_cycles), 32'd3);
      // branch, hazard during second flush cycle
      drv(0, 1, 0, 0, 0, 1);
      chk("br_state", 32'(state), 32'd1);
      drv(1, 0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 0, 1);
      chk("br_count", 32'(flush_count), 32'd1);
      // memory wait 4 cycles then ready
      drv(0, 0, 1, 0, 0, 4);
      drv(0, 0, 1, 1, 0, 1);
      drv(0, 0, 0, 0, 1, 2);
      // simultaneous events, branch re-presented after release
      drv(1, 1, 1, 0, 0, 2);
      drv(1, 1, 1, 1, 0, 1);
      drv(0, 1, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 0, 2);
      chk("simul_flush", 32'(flush_count), 32'd1);
      // memory timeout boundary
      drv(0, 0, 1, 0, 0, 63);
      chk("to_63", 32'(mem_timeout), 32'd0);
      drv(0, 0, 1, 0, 0, 1);
      chk("to_64", 32'(mem_timeout), 32'd1);
      drv(0, 0, 1, 0, 0, 3);
      drv(0, 0, 1, 1, 0, 1);
      drv(0, 0, 0, 0, 0, 2);
      chk("to_sticky", 32'(mem_timeout), 32'd1);
      drv(0, 0, 0, 0, 1, 1);
      chk("to_clr", 32'(mem_timeout), 32'd0);
      // hazard deadlock boundary
      drv(1, 0, 0, 0, 0, 8);
      chk("dl_8", 32'(haz_deadlock), 32'd0);
      drv(1, 0, 0, 0, 0, 1);
      chk("dl_9", 32'(haz_deadlock), 32'd1);
      drv(0, 0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 1, 1);
      // stall counter saturation
      drv(0, 0, 1, 0, 0, 260);
      chk("stall_sat", 32'(stall_cycles), CMAX);
      drv(0, 0, 1, 1, 0, 1);
      drv(0, 0, 0, 0, 1, 1);
      // async reset in FLUSH with one cycle remaining
      drv(0, 1, 0, 0, 0, 1);
      chk("pre_rst_state", 32'(state), 32'd1);
      branch_taken = 0;
      rst_n = 1'b0;
      #1 chk_reset_state("mid_reset");
      m_reset();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      drv(0, 1, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 0, 2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         hazard       = ($urandom_range(0, 99) < 45);
         branch_taken = ($urandom_range(0, 99) < 15);
         mem_req      = ($urandom_range(0, 99) < 20);
         mem_ready    = ($urandom_range(0, 99) < ((i % 500) < 100 ? 2 : 35));
         clr_stats    = ($urandom_range(0, 99) < 1);
         cycle();
      end
      drv(0, 0, 0, 1, 0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the hazard flag from the ID-stage hazard detection unit and turns it into pipeline-register control.
- Also handles the EXE-stage branch_taken redirect and the SRAM controller wait handshake (mem_req/mem_ready).
- Drives freeze, bubble and flush strobes to the PC, IF/ID, ID/EX and all-stage registers.
- Keeps sticky error flags and saturating stall/flush statistics.

Parameters:
- FLUSH_CYCLES, 1, total cycles flush strobes stay asserted per taken branch (1..15).
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles after which mem_timeout is set.
- HAZ_MAX, 8, consecutive hazard-stall cycles after which haz_deadlock is set.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- hazard  input  1  RAW hazard from the hazard detection unit.
- branch_taken  input  1  branch resolved taken in EXE this cycle.
- mem_req  input  1  MEM stage issues an SRAM access.
- mem_ready  input  1  SRAM controller completes the access this cycle.
- clr_stats  input  1  synchronous clear of the statistics counters and sticky flags.
- freeze_pc  output  1  hold the PC.
- freeze_if_id  output  1  hold the IF/ID register.
- bubble_id_ex  output  1  load a NOP (all enables 0) into ID/EX.
- flush_if_id  output  1  clear the IF/ID register.
- flush_id_ex  output  1  clear the ID/EX register.
- freeze_all  output  1  hold every pipeline register and the PC.
- mem_timeout  output  1  sticky: memory wait exceeded MEM_TIMEOUT.
- haz_deadlock  output  1  sticky: hazard held more than HAZ_MAX cycles.
- stall_cycles  output  CNT_W  saturating count of cycles with freeze_pc or freeze_all asserted.
- flush_count  output  CNT_W  saturating count of taken branches accepted.
- state  output  2  FSM state: RUN=0, FLUSH=1, MEM_WAIT=2.

Behaviour:
- Reset (rst_n=0, async): state=RUN, return-state=RUN, counters=0, sticky flags=0. All strobes deassert immediately.
- Strobes are Mealy: a function of the registered state and the current inputs, with zero-cycle latency. State, counters and flags update on the rising clk edge.
- Mem stall condition: mstall = mem_req && !mem_ready.
- Priority every cycle: mstall > branch_taken > hazard.

RUN state:
- If mstall: freeze_all=1, all other strobes 0. Save return-state=RUN, go to MEM_WAIT, wait counter=1.
- Else if branch_taken: flush_if_id=flush_id_ex=1, flush_count+1.
  - If FLUSH_CYCLES>1: load the remaining counter with FLUSH_CYCLES-1 and go to FLUSH.
  - If FLUSH_CYCLES=1: stay in RUN.
- Else if hazard: freeze_pc=freeze_if_id=bubble_id_ex=1 and the hazard-run counter increments. When the count exceeds HAZ_MAX, set haz_deadlock.
- Hazard-run counter: cleared on any cycle without a hazard stall; saturates at HAZ_MAX+1.

FLUSH state:
- If mstall: freeze_all=1, flush strobes 0, remaining counter held. Save return-state=FLUSH, go to MEM_WAIT.
- Otherwise: flush_if_id=flush_id_ex=1. Hazard is ignored (the flush already creates a bubble). Remaining counter decrements; go to RUN when it reaches 0.
- branch_taken seen in FLUSH: no new flush is counted (that instruction is being squashed).

MEM_WAIT state:
- freeze_all=1 while mem_ready=0. Wait counter increments and saturates; when the count reaches MEM_TIMEOUT, set mem_timeout.
- On the cycle mem_ready=1: freeze_all=0. Go to the saved return-state and clear the wait counter.
- hazard and branch_taken are ignored while frozen. Frozen registers re-present them after release.

Statistics and flags:
- stall_cycles increments on any cycle with freeze_pc or freeze_all asserted and saturates at all-ones.
- clr_stats zeroes both counters and both sticky flags next edge, with priority over increments. It does not change the FSM.

Invariants (assertions):
- freeze_all is never asserted together with any flush or bubble strobe.
- bubble_id_ex is always equal to freeze_pc.

Test Plan:
- Hazard stall: hazard=1 for 3 cycles in RUN -> freeze_pc/freeze_if_id/bubble_id_ex high exactly those 3 cycles, stall_cycles=3, haz_deadlock=0.
- Branch with FLUSH_CYCLES=2: branch_taken pulse -> flush strobes high 2 cycles, state RUN->FLUSH->RUN, flush_count=1. Hazard asserted in the 2nd cycle -> no bubble.
- Memory wait: mem_req=1 with mem_ready low 4 cycles then high -> freeze_all high 4 cycles, low on the ready cycle, state returns to RUN, stall_cycles=4.
- Simultaneous events: mstall, branch_taken and hazard in one cycle -> only freeze_all. After ready, with branch_taken still high -> flush, flush_count=1.
- Boundaries:
  - Memory wait held 64 cycles -> mem_timeout rises at the 64th MEM_WAIT cycle and stays high until clr_stats.
  - Hazard held 9 cycles -> haz_deadlock=1.
- Reset mid-operation: assert rst_n=0 in FLUSH with 1 cycle remaining -> strobes drop asynchronously, state=RUN, counters 0; normal operation resumes after release.
